// File: rtl/pcla_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-lookahead adder.
package pcla_pkg;

  typedef enum logic {
    PCLA_ADD = 1'b0,
    PCLA_SUB = 1'b1
  } pcla_op_e;

  // Number of lookahead blocks each pipeline stage resolves.
  function automatic int blocks_per_stage(input int width, input int block_size,
                                          input int stages);
    return (width / block_size) / stages;
  endfunction

  // Geometry legality: whole blocks, at least one stage, even spread of blocks.
  function automatic bit params_ok(input int width, input int block_size,
                                   input int stages);
    return (block_size > 0) && (stages >= 1) && (width > 0) &&
           (width % block_size == 0) &&
           ((width / block_size) % stages == 0);
  endfunction

endpackage

// File: rtl/pipelined_carry_lookahead_adder_cla_block.sv
// One combinational lookahead block: bit generate/propagate, group G/P,
// block carry-out from the group terms, sum bits rippled from the block carry-in.
module cla_block #(
  parameter int BLOCK_SIZE = 4
) (
  input  logic [BLOCK_SIZE-1:0] a,
  input  logic [BLOCK_SIZE-1:0] b,
  input  logic                  cin,
  output logic [BLOCK_SIZE-1:0] s,
  output logic                  G,
  output logic                  P,
  output logic                  cout
);

  logic [BLOCK_SIZE-1:0] g;
  logic [BLOCK_SIZE-1:0] p;
  logic                  grp_g;

  assign g = a & b;
  assign p = a | b;

  // Ripple the sum inside the block and fold the group generate LSB-first.
  always_comb begin
    logic c;
    c     = cin;
    grp_g = 1'b0;
    s     = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      s[i]  = a[i] ^ b[i] ^ c;
      c     = g[i] | (p[i] & c);
      grp_g = g[i] | (p[i] & grp_g);
    end
  end

  assign G    = grp_g;
  assign P    = &p;
  assign cout = G | (P & cin);

endmodule

// File: rtl/pipelined_carry_lookahead_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Each stage resolves an equal share of lookahead blocks and registers the
// partial sum, remaining operands, group carry and sign bits.
// Optional build macro: PCLA_SATURATE_EN clamps s to the signed extreme on overflow.
module pipelined_carry_lookahead_adder
  import pcla_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int BLOCK_SIZE = 4,
  parameter int STAGES     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = blocks_per_stage(WIDTH, BLOCK_SIZE, STAGES);
  localparam int SB = N * BLOCK_SIZE;

  if (!params_ok(WIDTH, BLOCK_SIZE, STAGES)) begin : g_bad_params
    $error("pipelined_carry_lookahead_adder: illegal WIDTH/BLOCK_SIZE/STAGES");
  end

  // Clamp to the signed extreme matching the sign of operand a.
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] val,
                                                input logic of,
                                                input logic a_msb);
    if (!of) return val;
    return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  // Stage registers: entry k is the register after stage k.
  logic [STAGES-1:0]            vld_p;
  logic [STAGES-1:0][WIDTH-1:0] sum_p;
  logic [STAGES-1:0][WIDTH-1:0] opa_p;
  logic [STAGES-1:0][WIDTH-1:0] opb_p;
  logic [STAGES-1:0]            cy_p;
  logic [STAGES-1:0]            am_p;
  logic [STAGES-1:0]            bm_p;
  logic                         ovf_p;

  // Next-state values produced by each stage's combinational slice.
  logic [STAGES-1:0]            v_in;
  logic [STAGES-1:0][WIDTH-1:0] sum_d;
  logic [STAGES-1:0][WIDTH-1:0] opa_d;
  logic [STAGES-1:0][WIDTH-1:0] opb_d;
  logic [STAGES-1:0]            cy_d;
  logic [STAGES-1:0]            am_d;
  logic [STAGES-1:0]            bm_d;
  logic                         ovf_d;
  logic [STAGES-1:0][N-1:0]     blk_g;
  logic [STAGES-1:0][N-1:0]     blk_p;

  // rdy[k]: stage k register can take new content this cycle.
  logic [STAGES:0]              rdy;

  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] sum_nx;
    logic [SB-1:0]    blk_s;
    logic [N:0]       cc;
    logic             c_in;
    logic             am_in;
    logic             bm_in;

    assign rdy[k] = !vld_p[k] || rdy[k+1];

    if (k == 0) begin : g_src_in
      assign a_in   = a;
      assign b_in   = (pcla_op_e'(op) == PCLA_SUB) ? ~b : b;
      assign c_in   = (pcla_op_e'(op) == PCLA_SUB) ? 1'b1 : cin;
      assign sum_in = '0;
      assign am_in  = a[WIDTH-1];
      assign bm_in  = b_in[WIDTH-1];
      assign v_in[k] = in_valid;
    end else begin : g_src_reg
      assign a_in   = opa_p[k-1];
      assign b_in   = opb_p[k-1];
      assign c_in   = cy_p[k-1];
      assign sum_in = sum_p[k-1];
      assign am_in  = am_p[k-1];
      assign bm_in  = bm_p[k-1];
      assign v_in[k] = vld_p[k-1];
    end

    assign cc[0] = c_in;

    for (genvar j = 0; j < N; j++) begin : g_blk
      cla_block #(.BLOCK_SIZE(BLOCK_SIZE)) u_blk (
        .a    (a_in[(k*N+j)*BLOCK_SIZE +: BLOCK_SIZE]),
        .b    (b_in[(k*N+j)*BLOCK_SIZE +: BLOCK_SIZE]),
        .cin  (cc[j]),
        .s    (blk_s[j*BLOCK_SIZE +: BLOCK_SIZE]),
        .G    (blk_g[k][j]),
        .P    (blk_p[k][j]),
        .cout (cc[j+1])
      );
    end

    // Splice this stage's block sums into the running partial sum.
    always_comb begin
      sum_nx = sum_in;
      sum_nx[k*SB +: SB] = blk_s;
    end

    assign opa_d[k] = a_in;
    assign opb_d[k] = b_in;
    assign cy_d[k]  = cc[N];
    assign am_d[k]  = am_in;
    assign bm_d[k]  = bm_in;

    if (k == STAGES-1) begin : g_fmt
      assign ovf_d = (am_in == bm_in) && (sum_nx[WIDTH-1] != am_in);
`ifdef PCLA_SATURATE_EN
      assign sum_d[k] = saturate(sum_nx, ovf_d, am_in);
`else
      assign sum_d[k] = sum_nx;
`endif
    end else begin : g_pass
      assign sum_d[k] = sum_nx;
    end
  end

  // Shift each stage register as a unit whenever it can take new content.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      sum_p <= '0;
      opa_p <= '0;
      opb_p <= '0;
      cy_p  <= '0;
      am_p  <= '0;
      bm_p  <= '0;
      ovf_p <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld_p[k] <= v_in[k];
          if (v_in[k]) begin
            sum_p[k] <= sum_d[k];
            opa_p[k] <= opa_d[k];
            opb_p[k] <= opb_d[k];
            cy_p[k]  <= cy_d[k];
            am_p[k]  <= am_d[k];
            bm_p[k]  <= bm_d[k];
          end
        end
      end
      if (rdy[STAGES-1] && v_in[STAGES-1]) ovf_p <= ovf_d;
    end
  end

  // Final-stage operand copies and group terms have no consumer.
  logic unused_bits;
  assign unused_bits = ^{opa_p[STAGES-1], opb_p[STAGES-1], am_p[STAGES-1],
                         bm_p[STAGES-1], blk_g, blk_p};

  assign out_valid = vld_p[STAGES-1];
  assign s         = sum_p[STAGES-1];
  assign cout      = cy_p[STAGES-1];
  assign ovf       = ovf_p;

endmodule

// File: tb/tb_pipelined_carry_lookahead_adder.sv
// Self-checking bench: directed literal vectors plus an arithmetic scoreboard
// model checked on every output transfer.
module tb_pipelined_carry_lookahead_adder;

  localparam int WIDTH = 32;
  localparam int BS    = 4;
  localparam int STG   = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  pipelined_carry_lookahead_adder #(.WIDTH(WIDTH), .BLOCK_SIZE(BS), .STAGES(STG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference arithmetic: wide unsigned/signed integers, no bit-level adder.
  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic mcin, input logic mop);
    exp_t        e;
    longint      ua, ub, r, sa, sb, sr;
    ua = longint'({32'h0, ma});
    ub = longint'({32'h0, mb});
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (mop) begin
      r   = ua - ub;
      e.c = (ua >= ub);
      sr  = sa - sb;
    end else begin
      r   = ua + ub + longint'(mcin);
      e.c = (r >= 64'sh1_0000_0000);
      sr  = sa + sb + longint'(mcin);
    end
    e.s = r[31:0];
    e.o = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
`ifdef PCLA_SATURATE_EN
    if (e.o) e.s = ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return e;
  endfunction

  // Scoreboard: record accepted ops, check every output transfer and hold stability.
  logic        hold_v = 1'b0;
  logic [31:0] held_s;
  logic        held_c, held_o;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_s", {32'h0, s}, {32'h0, held_s});
        chk("hold_cout_ovf", {62'h0, cout, ovf}, {62'h0, held_c, held_o});
      end
      hold_v = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (q.size() == 0) begin
            chk("spurious_out_valid", 64'h1, 64'h0);
          end else begin
            e = q.pop_front();
            chk("sb_s", {32'h0, s}, {32'h0, e.s});
            chk("sb_cout", {63'h0, cout}, {63'h0, e.c});
            chk("sb_ovf", {63'h0, ovf}, {63'h0, e.o});
          end
        end else begin
          hold_v = 1'b1;
          held_s = s;
          held_c = cout;
          held_o = ovf;
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cin, op));
    end
  end

  // One operation with out_ready high: check latency and literal results.
  task automatic run_one(input string nm, input logic [31:0] ta, input logic [31:0] tb,
                         input logic tc, input logic top, input logic [31:0] es,
                         input logic ec, input logic eo);
    int lat;
    a = ta; b = tb; cin = tc; op = top; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(STG));
    chk({nm, "_s"}, {32'h0, s}, {32'h0, es});
    chk({nm, "_cout"}, {63'h0, cout}, {63'h0, ec});
    chk({nm, "_ovf"}, {63'h0, ovf}, {63'h0, eo});
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t pin;
    int   waitc, acc, cyc;
    logic took;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_s", {32'h0, s}, 64'h0);
    chk("rst_cout_ovf", {62'h0, cout, ovf}, 64'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {63'h0, in_ready}, 64'h1);

    // Model pinned against hand-computed literals.
    pin = model(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    chk("model_wrap", {31'h0, pin}, {31'h0, 32'h0, 1'b1, 1'b0});
    pin = model(32'd5, 32'd7, 1'b0, 1'b1);
    chk("model_sub_borrow", {31'h0, pin}, {31'h0, 32'hFFFF_FFFE, 1'b0, 1'b0});

    @(posedge clk); #1;
    run_one("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    run_one("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_one("sub_7_5_cin", 32'd7, 32'd5, 1'b1, 1'b1, 32'd2, 1'b1, 1'b0);
    run_one("add_cin", 32'd1, 32'd2, 1'b1, 1'b0, 32'd4, 1'b0, 1'b0);
`ifdef PCLA_SATURATE_EN
    run_one("add_ovf_pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_one("add_ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
`else
    run_one("add_ovf_pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_one("add_ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
`endif

    // Backpressure: two ops fill the pipe, the third stalls.
    out_ready = 1'b0; op = 1'b0; cin = 1'b0;
    a = 32'd1; b = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'd2; b = 32'd2;
    @(posedge clk); #1;
    a = 32'd3; b = 32'd3;
    chk("bp_in_ready_full", {63'h0, in_ready}, 64'h0);
    chk("bp_first_s", {32'h0, s}, 64'd2);
    @(posedge clk); #1;
    chk("bp_still_full", {63'h0, in_ready}, 64'h0);
    chk("bp_held_s", {32'h0, s}, 64'd2);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_chain", {63'h0, in_ready}, 64'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second", {31'h0, out_valid, s}, {31'h0, 1'b1, 32'd4});
    @(posedge clk); #1;
    chk("bp_third", {31'h0, out_valid, s}, {31'h0, 1'b1, 32'd6});
    @(posedge clk); #1;
    chk("bp_drained", {63'h0, out_valid}, 64'h0);

    // Reset with two ops in flight.
    a = 32'd10; b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'd30; b = 32'd40;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_mid_s", {32'h0, s}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("no_stale_result", {63'h0, out_valid}, 64'h0);
    end

    // Sustained throughput with out_ready held high.
    acc = 0; cyc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom); op = 1'($urandom);
      #3;
      if (in_ready) acc++;
      cyc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("throughput", 64'(acc), 64'(cyc));
    repeat (4) @(posedge clk);
    #1;

    // Random ops with random backpressure, checked by the scoreboard.
    for (int n = 0; n < 10000; n++) begin
      case ($urandom_range(0, 7))
        0: a = 32'h7FFF_FFFF;
        1: a = 32'h8000_0000;
        2: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'h7FFF_FFFF;
        1: b = 32'h8000_0000;
        2: b = 32'h0;
        default: b = $urandom;
      endcase
      cin = 1'($urandom); op = 1'($urandom);
      in_valid = 1'b1;
      waitc = 0;
      do begin
        @(negedge clk);
        took = in_ready;
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
        waitc++;
      end while (!took && waitc < 1000);
      if (!took) chk("rand_accept_timeout", 64'h1, 64'h0);
      in_valid = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        @(posedge clk); #1;
      end
    end

    out_ready = 1'b1;
    waitc = 0;
    while (q.size() != 0 && waitc < 100) begin
      @(posedge clk); #1;
      waitc++;
    end
    chk("drain_empty", 64'(q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_carry_lookahead_adder.md
# pipelined_carry_lookahead_adder

Pipelined, parametrised carry-lookahead adder/subtractor with a valid/ready stream interface. Operands are split into lookahead blocks of `BLOCK_SIZE` bits, and the blocks are spread evenly over `STAGES` register stages, with the group carry registered between stages. It accepts one operation per cycle at full throughput. It is the datapath successor to the combinational lookahead adder and is intended for ALU and accumulator paths whose width would otherwise break timing.

## Interface
- `WIDTH`, 32: operand and result width; must be a multiple of `BLOCK_SIZE`.
- `BLOCK_SIZE`, 4: bits per lookahead block.
- `STAGES`, 2: number of pipeline register stages; must be ≥1 and must divide `WIDTH/BLOCK_SIZE`.
- `clk` input 1: the single clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operation presented.
- `in_ready` output 1: stage 0 can accept.
- `a`, `b` input `WIDTH`: operands.
- `cin` input 1: carry-in; ignored when `op` is SUB.
- `op` input 1: 0 = ADD, 1 = SUB.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts result.
- `s` output `WIDTH`: result.
- `cout` output 1: unsigned carry-out. For SUB, 1 means no borrow.
- `ovf` output 1: two's-complement signed overflow.

## Operation
- ADD computes `a + b + cin`. SUB computes `a + ~b + 1`: `b` is inverted and the carry-in is forced to 1 at stage 0 input.
- Per block: `g = a & b`, `p = a | b`. Group `G` and `P` are formed by the lookahead recurrence, and the block carry-out is `G | (P & cin_block)`.
- Sum bits within a block ripple from the block carry-in.
- Stage k handles blocks `k*N .. k*N+N-1`, where `N = WIDTH/BLOCK_SIZE/STAGES`. Its last block carry-out is registered as the carry-in of stage k+1.
- Each stage register holds the following fields, shifted as a unit:
  - the sum bits completed so far;
  - the not-yet-used operand bits (already inverted for SUB);
  - the inter-stage carry;
  - the operand MSB sign bits needed for `ovf`;
  - a valid bit.
- `ovf = (a_msb == b'_msb) && (s_msb != a_msb)`, where `b'` is the post-inversion operand.
- Stall rule: stage k advances when its downstream stage is empty or advancing. The last stage advances on `out_ready`.
- `in_ready` = stage 0 empty or stage 0 advancing.
- Transfers occur only on `valid && ready`. Results emerge strictly in acceptance order; nothing is dropped or duplicated.

## Timing
- Latency: `STAGES` cycles from accepting edge to `out_valid` high, when unstalled.
- Throughput: one operation per cycle while `out_ready` is held high.
- `s`, `cout`, `ovf` are registered outputs. They are held stable while `out_valid && !out_ready`.
- Reset values: `out_valid=0`, `s=0`, `cout=0`, `ovf=0`, all stage valid bits 0. `in_ready` reads 1 after reset.
- Reset mid-operation: all in-flight operations are discarded. No `out_valid` may appear for a pre-reset operation.
- Full pipeline with `out_ready=0`: after `STAGES` accepted operations, `in_ready=0`.
- Simultaneous pop and push at a full pipeline: both occur in the same cycle, with no bubble.
- `in_ready` may depend combinationally on `out_ready`, as a ready chain through the stages. No combinational path exists from `in_valid` to `out_valid`.

## Configuration
- `PCLA_SATURATE_EN` defined:
  - on `ovf=1`, `s` is clamped to the signed extreme: `0x7FF..F` if `a_msb==0`, else `0x800..0`;
  - `cout` is unaffected.
- Undefined: `s` is the wrapped result, and `ovf` is still reported.

## Structure
- Package `pcla_pkg` contains:
  - the `pcla_op_e` enum (`PCLA_ADD`, `PCLA_SUB`);
  - a function returning blocks per stage;
  - elaboration-time parameter checks.
- Sub-module `cla_block`: one combinational `BLOCK_SIZE`-bit lookahead block. Inputs are `a`, `b`, `cin`; outputs are `s`, `G`, `P`, `cout`. It is instantiated `N` times per stage.
- The top level contains only stage registers, handshake logic and output formatting.

## Test plan
All scenarios use `WIDTH=32`, `BLOCK_SIZE=4`, `STAGES=2`.
- ADD `0xFFFF_FFFF + 0x0000_0001`, `cin=0` → after 2 cycles: `s=0x0000_0000`, `cout=1`, `ovf=0`.
- SUB `5 - 7` → `s=0xFFFF_FFFE`, `cout=0`, `ovf=0`. SUB `7 - 5` → `s=2`, `cout=1`.
- ADD `0x7FFF_FFFF + 1` → `ovf=1`. Without the macro `s=0x8000_0000`; with `PCLA_SATURATE_EN` `s=0x7FFF_FFFF`.
- Backpressure: 3 back-to-back ops (`1+1`, `2+2`, `3+3`) with `out_ready=0`.
  - First two are accepted; `in_ready=0` on the third.
  - On releasing `out_ready`, results appear as `2`, `4`, `6` on consecutive cycles.
- Reset: `rst_n` pulsed low with 2 ops in flight → `out_valid=0` and `s=0` immediately. No stale result appears after release.
- Random: 10,000 random ops with random `out_ready` toggling, checked against a scoreboard model.
  - With `out_ready` held at 1, sustained throughput is 1 op/cycle.
